regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32: width of each register and data port, in bits.
REQ-002 Parameter ADDR_W, default 5: register index width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 always reads 0, ignores writes and is never busy.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 ctrl_reset  in  1  reset, asynchronous, active-high.
REQ-006 ctrl_writeEnable  in  1  writeback strobe.
REQ-007 ctrl_writeReg  in  ADDR_W  writeback destination index.
REQ-008 data_writeReg  in  DATA_W  writeback data.
REQ-009 ctrl_readRegA / ctrl_readRegB  in  ADDR_W  read port A / B index.
REQ-010 data_readRegA / data_readRegB  out  DATA_W  read port A / B data.
REQ-011 ctrl_issueEnable  in  1  marks ctrl_issueReg as having a write in flight.
REQ-012 ctrl_issueReg  in  ADDR_W  destination of the issued instruction.
REQ-013 busy_readRegA / busy_readRegB  out  1  read port A / B operand not yet valid.
REQ-014 pending_count  out  ADDR_W+1  number of registers currently marked busy.

Function
REQ-015 The storage array SHALL update at the rising clock edge when ctrl_writeEnable=1, except index 0 when ZERO_REG=1.
REQ-016 Read ports SHALL be combinational with zero-cycle latency.
REQ-017 Write-through bypass: with ctrl_writeEnable=1 and ctrl_writeReg equal to a port's read index (not 0 when ZERO_REG=1), that port SHALL return data_writeReg in the same cycle.
REQ-018 Scoreboard: one busy bit per register; issue sets the bit at the edge; a writeback to a busy register clears it at the edge.
REQ-019 Simultaneous issue and writeback to the same index: the bit SHALL remain/become 1 (issue wins); the data is still written.
REQ-020 Issue to an already-busy register SHALL leave the bit at 1; writeback to a non-busy register SHALL only write data.
REQ-021 busy_readRegX SHALL equal busy[idx] AND NOT (same-cycle writeback to idx without same-cycle issue to idx), so bypassed operands are not busy.
REQ-022 Index 0 with ZERO_REG=1: issue ignored, busy output 0, data output 0.
REQ-023 pending_count SHALL be a registered counter: +1 on a 0->1 busy transition, -1 on 1->0, unchanged otherwise or when both occur on different indices; it never wraps (max DEPTH).

Reset
REQ-024 ctrl_reset=1 SHALL immediately clear all registers, all busy bits and pending_count to 0, independent of clock.
REQ-025 While ctrl_reset=1, writes and issues SHALL be ignored; data outputs SHALL read 0 apart from bypass; busy outputs SHALL read 0.
REQ-026 Operation SHALL resume at the first rising edge after ctrl_reset deasserts; reset asserted mid-flight discards all pending state.

Structure
REQ-027 Package regfile_pkg SHALL hold the DATA_W/ADDR_W defaults and the DEPTH derivation, shared with the processor datapath.
REQ-028 Busy bits and pending_count SHALL live in sub-module regfile_scoreboard; storage and bypass SHALL sit in regfile_sb.

Verification
REQ-029 Reset, write r5=0xDEADBEEF, read A=5 next cycle -> 0xDEADBEEF; read A=0 after writing r0=0x1234 -> 0x00000000.
REQ-030 Write r7=0xA5A5A5A5 with read B=7 in the same cycle -> data_readRegB=0xA5A5A5A5, busy_readRegB=0.
REQ-031 Issue r3 -> next cycle busy_readRegA=1 (A=3), pending_count=1; writeback r3=0x55 -> busy 0 that cycle, pending_count=0 after the edge.
REQ-032 Issue r9 while writing back r9 -> busy stays 1, pending_count 0->1, r9 holds the written data.
REQ-033 Issue r1..r31 over consecutive cycles -> pending_count=31; reissue r4 -> stays 31; assert ctrl_reset asynchronously mid-clock -> count, busy and data 0 at once.
REQ-034 DATA_W=16, ADDR_W=3 build: write r7=0xFFFF, read -> 0xFFFF; pending_count width 4, maximum 7.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file sizing: default widths and the register count derivation
// used by both the register file and the processor datapath.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking for in-flight writes, with a running count of
// busy registers and the per-read-port "operand not yet valid" flags.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_idx,
  input  logic              i_iss_en,
  input  logic [ADDR_W-1:0] i_iss_idx,
  input  logic [ADDR_W-1:0] i_rd_a,
  input  logic [ADDR_W-1:0] i_rd_b,
  output logic              o_busy_a,
  output logic              o_busy_b,
  output logic [ADDR_W:0]   o_pending
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int CW    = ADDR_W + 1;

  logic [DEPTH-1:0] r_busy;
  logic [CW-1:0]    r_pending;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [CW-1:0]    w_pending_nxt;
  logic             w_iss_ok;
  logic             w_wb_ok;
  logic             w_same_idx;
  logic             w_set_ev;
  logic             w_clr_ev;
  logic             w_byp_a;
  logic             w_byp_b;

  assign w_iss_ok   = i_iss_en && !((ZERO_REG != 0) && (i_iss_idx == '0));
  assign w_wb_ok    = i_wb_en  && !((ZERO_REG != 0) && (i_wb_idx  == '0));
  assign w_same_idx = w_iss_ok && (i_iss_idx == i_wb_idx);
  assign w_set_ev   = w_iss_ok && !r_busy[i_iss_idx];
  assign w_clr_ev   = w_wb_ok && r_busy[i_wb_idx] && !w_same_idx;

  // Issue takes priority over writeback when both target the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      w_busy_nxt[i] = (w_iss_ok && (i_iss_idx == ADDR_W'(i))) ? 1'b1 :
                      (w_wb_ok  && (i_wb_idx  == ADDR_W'(i))) ? 1'b0 : r_busy[i];
    end
  end

  // Count follows busy transitions; one set and one clear cancel out.
  always_comb begin
    w_pending_nxt = r_pending;
    case ({w_set_ev, w_clr_ev})
      2'b10: begin
        if (r_pending != CW'(DEPTH)) w_pending_nxt = r_pending + CW'(1);
        else                         w_pending_nxt = r_pending;
      end
      2'b01: begin
        if (r_pending != CW'(0)) w_pending_nxt = r_pending - CW'(1);
        else                     w_pending_nxt = r_pending;
      end
      default: w_pending_nxt = r_pending;
    endcase
  end

  // Busy bits and pending count state.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign w_byp_a   = w_wb_ok && (i_wb_idx == i_rd_a) && !(w_iss_ok && (i_iss_idx == i_rd_a));
  assign w_byp_b   = w_wb_ok && (i_wb_idx == i_rd_b) && !(w_iss_ok && (i_iss_idx == i_rd_b));
  assign o_busy_a  = r_busy[i_rd_a] && !w_byp_a;
  assign o_busy_b  = r_busy[i_rd_b] && !w_byp_b;
  assign o_pending = r_pending;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-through bypass and an
// issue/writeback scoreboard for tracking operands still in flight.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic              ctrl_issueEnable,
  input  logic [ADDR_W-1:0] ctrl_issueReg,
  output logic              busy_readRegA,
  output logic              busy_readRegB,
  output logic [ADDR_W:0]   pending_count
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_ok;

  assign w_wr_ok = ctrl_writeEnable && !((ZERO_REG != 0) && (ctrl_writeReg == '0));

  // Storage array; reset clears every entry without waiting for a clock.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[ctrl_writeReg] <= data_writeReg;
    end
  end

  // Read port A: bypass first, hardwired zero register next, then storage.
  always_comb begin
    data_readRegA = r_mem[ctrl_readRegA];
    if (w_wr_ok && (ctrl_writeReg == ctrl_readRegA)) data_readRegA = data_writeReg;
    else if ((ZERO_REG != 0) && (ctrl_readRegA == '0)) data_readRegA = '0;
    else data_readRegA = r_mem[ctrl_readRegA];
  end

  // Read port B, same priority as port A.
  always_comb begin
    data_readRegB = r_mem[ctrl_readRegB];
    if (w_wr_ok && (ctrl_writeReg == ctrl_readRegB)) data_readRegB = data_writeReg;
    else if ((ZERO_REG != 0) && (ctrl_readRegB == '0)) data_readRegB = '0;
    else data_readRegB = r_mem[ctrl_readRegB];
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .i_wb_en    (ctrl_writeEnable),
    .i_wb_idx   (ctrl_writeReg),
    .i_iss_en   (ctrl_issueEnable),
    .i_iss_idx  (ctrl_issueReg),
    .i_rd_a     (ctrl_readRegA),
    .i_rd_b     (ctrl_readRegB),
    .o_busy_a   (busy_readRegA),
    .o_busy_b   (busy_readRegB),
    .o_pending  (pending_count)
  );

endmodule
